fetch_decode_pipe: RTL
======================

# fetch_decode_pipe

Sequential consumer of the load-use hazard signals (`PC_WriteEnable`, `IFID_WriteEnable`, `StallFlush`) in the 5-stage MIPS pipeline.
- Owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register.
- Applies stalls, branch flushes and bubble insertion.
- Keeps hazard statistics and a stuck-stall watchdog.
- Sits between instruction memory, the decode stage and the stall control unit.

## Interface
Parameters:
- CTRL_WIDTH, 10, width of the ID-stage control bundle passed to EX
- RESET_PC, 32'h0000_0000, PC value after reset
- MAX_STALL, 3, consecutive stall cycles tolerated before `StallError`

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- PC_WriteEnable  input  1  0 = hold PC
- IFID_WriteEnable  input  1  0 = hold IF/ID register
- StallFlush  input  1  1 = load bubble (zero control) into ID/EX
- ID_BranchTaken  input  1  branch/jump resolved taken in ID
- ID_BranchTarget  input  32  target address for a taken branch
- IF_Instruction  input  32  instruction memory read data at `PC`
- ID_Control  input  CTRL_WIDTH  decoded control bundle of the ID instruction
- PC  output  32  current fetch address
- IFID_PC4  output  32  PC+4 of the instruction in ID
- IFID_Instruction  output  32  instruction in ID
- IFID_Valid  output  1  0 = IF/ID holds a flushed NOP
- IDEX_Control  output  CTRL_WIDTH  control bundle presented to EX
- IDEX_Bubble  output  1  1 = current EX control is an inserted bubble
- StallCount  output  16  saturating count of stall cycles
- FlushCount  output  16  saturating count of branch flushes
- StallError  output  1  sticky watchdog flag

## Operation
- Reset values:
  - `PC` = RESET_PC.
  - `IFID_PC4`, `IFID_Instruction`, `IDEX_Control`, `StallCount` and `FlushCount` = 0.
  - `IFID_Valid` = 0.
  - `IDEX_Bubble` = 1.
  - `StallError` = 0.
  - Consecutive-stall counter = 0.
- A stall is the condition `PC_WriteEnable`=0 or `IFID_WriteEnable`=0 or `StallFlush`=1.
- PC next-state, in priority order:
  - `PC_WriteEnable`=0: hold.
  - else `ID_BranchTaken`=1: `ID_BranchTarget`.
  - else `PC`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID next-state, in priority order:
  - `IFID_WriteEnable`=0: hold all fields, including `IFID_Valid`.
  - else `ID_BranchTaken`=1: `IFID_Instruction`=0, `IFID_PC4`=0, `IFID_Valid`=0 (flush).
  - else load `IF_Instruction`, `PC`+4, `IFID_Valid`=1.
- ID/EX control next-state:
  - `StallFlush`=1 or `IFID_Valid`=0: `IDEX_Control`=0, `IDEX_Bubble`=1.
  - else `IDEX_Control`=`ID_Control`, `IDEX_Bubble`=0.
- Stall has priority over branch. During a stall, `ID_BranchTaken` is ignored for PC, IF/ID and `FlushCount`: the ID instruction's operands are not yet valid. The branch re-evaluates in the cycle after the stall releases.
- `StallCount` increments each stall cycle. `FlushCount` increments each non-stalled cycle with `ID_BranchTaken`=1. Both saturate at 16'hFFFF.
- Watchdog counter:
  - Increments on each stall cycle, clears on any non-stall cycle, saturates at MAX_STALL+1.
  - `StallError` sets when the counter reaches MAX_STALL+1, i.e. on the (MAX_STALL+1)-th consecutive stall cycle.
  - `StallError` clears only on reset.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Stall response: inputs sampled at edge N take effect in outputs after edge N.
- Load-use stall of one cycle:
  - PC and IF/ID hold for exactly one edge.
  - One bubble enters EX.
  - The stalled instruction enters EX on the following edge.
- Taken-branch penalty: one NOP in IF/ID. `PC` shows the target one edge after the branch is sampled.
- Reset asserted mid-stall or mid-flush overrides everything on that edge. The first fetch after reset deassertion is from RESET_PC.
- First valid instruction reaches IF/ID one edge after reset deasserts. `IDEX_Bubble` stays 1 until that instruction advances.

## Test plan
- Reset then free-run 4 cycles with no stall or branch, `IF_Instruction` = 32'h8C01_0000, 32'h0022_1820, ... -> `PC` steps 0, 4, 8, 12 and `IFID_PC4` tracks `PC`.
- Single load-use stall (`PC_WriteEnable`=0, `IFID_WriteEnable`=0, `StallFlush`=1 for one cycle) with `PC`=8 -> `PC` stays 8 for one extra cycle; `IDEX_Control`=0 and `IDEX_Bubble`=1 for one cycle; `StallCount`=1.
- `ID_BranchTaken`=1 with `ID_BranchTarget`=32'h40 and no stall -> next `PC`=32'h40; `IFID_Valid`=0 and `IFID_Instruction`=0 for one cycle; bubble in EX the cycle after; `FlushCount`=1.
- Stall and `ID_BranchTaken`=1 in the same cycle -> `PC` holds and `FlushCount` stays unchanged; with the branch held for the next unstalled cycle, `PC` then loads the target.
- Stall held 4 consecutive cycles with MAX_STALL=3 -> `StallError`=1 after the 4th edge and remains 1 after the stall releases; reset clears it.
- Reset asserted during a stall at `PC`=32'h1C with `StallCount`=5 -> `PC`=RESET_PC, all counters 0, `IFID_Valid`=0, `IDEX_Bubble`=1 on the next edge.

Source files
------------

// File: rtl/fetch_decode_pipe_if.sv
// Bus between the fetch/decode pipe and its neighbours: the stall control
// unit, instruction memory and the decode stage. The pipe is the slave; the
// surrounding pipeline (or a testbench) is the master.
interface fetch_decode_pipe_if #(
  parameter int CTRL_WIDTH = 10
);
  // Hazard controls from the stall unit
  logic                  PC_WriteEnable;
  logic                  IFID_WriteEnable;
  logic                  StallFlush;
  // Branch resolution from ID
  logic                  ID_BranchTaken;
  logic [31:0]           ID_BranchTarget;
  // Instruction memory read data and decoded control
  logic [31:0]           IF_Instruction;
  logic [CTRL_WIDTH-1:0] ID_Control;
  // Registered pipeline state
  logic [31:0]           PC;
  logic [31:0]           IFID_PC4;
  logic [31:0]           IFID_Instruction;
  logic                  IFID_Valid;
  logic [CTRL_WIDTH-1:0] IDEX_Control;
  logic                  IDEX_Bubble;
  logic [15:0]           StallCount;
  logic [15:0]           FlushCount;
  logic                  StallError;

  modport slave (
    input  PC_WriteEnable, IFID_WriteEnable, StallFlush,
    input  ID_BranchTaken, ID_BranchTarget, IF_Instruction, ID_Control,
    output PC, IFID_PC4, IFID_Instruction, IFID_Valid,
    output IDEX_Control, IDEX_Bubble, StallCount, FlushCount, StallError
  );

  modport master (
    output PC_WriteEnable, IFID_WriteEnable, StallFlush,
    output ID_BranchTaken, ID_BranchTarget, IF_Instruction, ID_Control,
    input  PC, IFID_PC4, IFID_Instruction, IFID_Valid,
    input  IDEX_Control, IDEX_Bubble, StallCount, FlushCount, StallError
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// PC register, IF/ID register and the control half of ID/EX for a 5-stage
// MIPS pipeline. Applies load-use stalls, taken-branch flushes and bubble
// insertion, and keeps stall/flush statistics plus a stuck-stall watchdog.
//
// Enable semantics: there is no valid/ready pair here. A write enable of 0
// means "hold this register on the next edge"; StallFlush=1 means "load a
// bubble into ID/EX on the next edge". Every output is a register.
module fetch_decode_pipe #(
  parameter int          CTRL_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MAX_STALL  = 3
) (
  input logic               clk,
  input logic               reset,
  fetch_decode_pipe_if.slave bus
);
  localparam int                   WdWidth  = $clog2(MAX_STALL + 2);
  localparam logic [WdWidth-1:0]   WdLimit  = WdWidth'(MAX_STALL + 1);
  localparam logic [WdWidth-1:0]   WdArm    = WdWidth'(MAX_STALL);

  logic               stall;
  logic               takeBranch;
  logic [31:0]        pcPlus4;
  logic [WdWidth-1:0] stallRun;

  // Stall dominates branch: a branch seen during a stall re-evaluates later
  always_comb begin
    stall      = !bus.PC_WriteEnable || !bus.IFID_WriteEnable || bus.StallFlush;
    takeBranch = bus.ID_BranchTaken && !stall;
    pcPlus4    = bus.PC + 32'd4;
  end

  // PC register: hold, redirect to branch target, or sequential fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.PC <= RESET_PC;
    end else if (bus.PC_WriteEnable) begin
      bus.PC <= takeBranch ? bus.ID_BranchTarget : pcPlus4;
    end
  end

  // IF/ID register: hold, flush to NOP on taken branch, or capture fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.IFID_PC4         <= 32'd0;
      bus.IFID_Instruction <= 32'd0;
      bus.IFID_Valid       <= 1'b0;
    end else if (bus.IFID_WriteEnable) begin
      if (takeBranch) begin
        bus.IFID_PC4         <= 32'd0;
        bus.IFID_Instruction <= 32'd0;
        bus.IFID_Valid       <= 1'b0;
      end else begin
        bus.IFID_PC4         <= pcPlus4;
        bus.IFID_Instruction <= bus.IF_Instruction;
        bus.IFID_Valid       <= 1'b1;
      end
    end
  end

  // ID/EX control: bubble when stalled or when ID holds a flushed NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.IDEX_Control <= '0;
      bus.IDEX_Bubble  <= 1'b1;
    end else if (bus.StallFlush || !bus.IFID_Valid) begin
      bus.IDEX_Control <= '0;
      bus.IDEX_Bubble  <= 1'b1;
    end else begin
      bus.IDEX_Control <= bus.ID_Control;
      bus.IDEX_Bubble  <= 1'b0;
    end
  end

  // Saturating statistics: stall cycles and taken-branch flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.StallCount <= 16'd0;
      bus.FlushCount <= 16'd0;
    end else begin
      if (stall && bus.StallCount != 16'hFFFF) begin
        bus.StallCount <= bus.StallCount + 16'd1;
      end
      if (takeBranch && bus.FlushCount != 16'hFFFF) begin
        bus.FlushCount <= bus.FlushCount + 16'd1;
      end
    end
  end

  // Watchdog: run length of consecutive stalls, sticky error on overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      stallRun       <= '0;
      bus.StallError <= 1'b0;
    end else if (stall) begin
      if (stallRun != WdLimit) begin
        stallRun <= stallRun + 1'b1;
      end
      if (stallRun >= WdArm) begin
        bus.StallError <= 1'b1;
      end
    end else begin
      stallRun <= '0;
    end
  end
endmodule
